// File: rtl/sort_cmp_pkg.sv
// Shared types and constants for the bubble-sort controller.
package sort_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SWAP_CNT_W = 8;
    localparam logic [SWAP_CNT_W-1:0] SWAP_CNT_MAX = 8'd255;

endpackage

// File: rtl/gt_compare_w.sv
// Unsigned strictly-greater-than comparator shared by every compare slot.
module gt_compare_w #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    // Strict compare keeps equal words in place, which makes the sort stable.
    assign gt = (a > b);

endmodule

// File: rtl/sort_cmp_controller.sv
// Sequential bubble-sort engine: one compare/swap per clock through a single
// shared comparator, host loads serially and reads results by address.
module sort_cmp_controller
    import sort_cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [SWAP_CNT_W-1:0]    swap_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_I    = AW'(DEPTH - 2);
    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

    state_t                      state;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               i;
    logic [AW-1:0]               i_nxt;
    logic                        swapped;
    logic [WIDTH-1:0]            cmp_a;
    logic [WIDTH-1:0]            cmp_b;
    logic                        gt;

    // Index muxes steer the adjacent pair under test into the comparator.
    assign i_nxt = i + 1'b1;
    assign cmp_a = mem[i];
    assign cmp_b = mem[i_nxt];

    gt_compare_w #(.WIDTH(WIDTH)) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (gt)
    );

    // Live read port; during a sort it shows the partially sorted array.
    assign rd_data = mem[rd_addr];

    // Controller FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem        <= '0;
            wr_ptr     <= '0;
            i          <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A load coinciding with start still lands and joins the sort.
                    if (load_valid) begin
                        mem[wr_ptr] <= load_data;
                        wr_ptr      <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
                    end
                    if (start) begin
                        state      <= SORT;
                        i          <= '0;
                        swapped    <= 1'b0;
                        swap_count <= '0;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SORT: begin
                    if (gt) begin
                        mem[i]     <= cmp_b;
                        mem[i_nxt] <= cmp_a;
                        swapped    <= 1'b1;
                        if (swap_count != SWAP_CNT_MAX)
                            swap_count <= swap_count + 1'b1;
                    end
                    if (i != LAST_I) begin
                        i <= i_nxt;
                    end else if (swapped || gt) begin
                        // Pass made progress: run another full-length pass.
                        i       <= '0;
                        swapped <= 1'b0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                    wr_ptr     <= '0;
                end
                default: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
